// File: rtl/ltz_cdc_debounce.sv
// Multi-channel CDC synchroniser with per-channel stability filter.
// Optional registered rise/fall outputs when LTZ_CDCDB_EDGE_EN is defined.

module ltz_cdc_debounce_lane #(
    parameter logic INIT       = 1'b0,
    parameter int   STABLE_CNT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic samp,
    output logic dout,
    output logic chg
`ifdef LTZ_CDCDB_EDGE_EN
    ,
    output logic rise,
    output logic fall
`endif
);
    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          dout_q, dout_d;
    logic          chg_q, chg_d;
`ifdef LTZ_CDCDB_EDGE_EN
    logic          rise_q, fall_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            dout_q <= INIT;
            chg_q  <= 1'b0;
`ifdef LTZ_CDCDB_EDGE_EN
            rise_q <= 1'b0;
            fall_q <= 1'b0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            chg_q  <= chg_d;
`ifdef LTZ_CDCDB_EDGE_EN
            rise_q <= chg_d & dout_d;
            fall_q <= chg_d & ~dout_d;
`endif
        end
    end

    // Any sample matching dout clears the run, so glitches never accumulate.
    always_comb begin
        cnt_d  = '0;
        dout_d = dout_q;
        chg_d  = 1'b0;
        if (samp != dout_q) begin
            if (cnt_q == CNT_MAX) begin
                dout_d = samp;
                chg_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        dout = dout_q;
        chg  = chg_q;
`ifdef LTZ_CDCDB_EDGE_EN
        rise = rise_q;
        fall = fall_q;
`endif
    end
endmodule

module ltz_cdc_debounce #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] INITVAL     = {WIDTH{1'b0}},
    parameter int               SYNC_STAGES = 2,
    parameter int               STABLE_CNT  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] chg
`ifdef LTZ_CDCDB_EDGE_EN
    ,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`endif
);
    if (SYNC_STAGES < 1 || STABLE_CNT < 1) begin : g_bad_param
        $error("ltz_cdc_debounce: SYNC_STAGES and STABLE_CNT must be >= 1");
    end

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  samp;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{INITVAL}};
        end else begin
            sync_q[0] <= din;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign samp = sync_q[SYNC_STAGES-1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        ltz_cdc_debounce_lane #(
            .INIT       (INITVAL[i]),
            .STABLE_CNT (STABLE_CNT)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .samp (samp[i]),
            .dout (dout[i]),
            .chg  (chg[i])
`ifdef LTZ_CDCDB_EDGE_EN
            ,
            .rise (rise[i]),
            .fall (fall[i])
`endif
        );
    end
endmodule

// File: tb/tb_ltz_cdc_debounce.sv
// Bench for ltz_cdc_debounce: directed vector table, random run against a
// sample-window reference model, and a STABLE_CNT=1 / SYNC_STAGES=3 instance.

module tb_ltz_cdc_debounce;
    localparam int W  = 4;
    localparam int SS = 2;
    localparam int SC = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, rst6;
    logic [W-1:0] din, dout, chg;
    logic [W-1:0] din6, dout6, chg6;
`ifdef LTZ_CDCDB_EDGE_EN
    logic [W-1:0] rise, fall, rise6, fall6;
`endif

    ltz_cdc_debounce #(.WIDTH(W), .INITVAL(4'h0), .SYNC_STAGES(SS), .STABLE_CNT(SC)) dut (
        .clk(clk), .rst(rst), .din(din), .dout(dout), .chg(chg)
`ifdef LTZ_CDCDB_EDGE_EN
        , .rise(rise), .fall(fall)
`endif
    );

    ltz_cdc_debounce #(.WIDTH(W), .INITVAL(4'hA), .SYNC_STAGES(3), .STABLE_CNT(1)) dut6 (
        .clk(clk), .rst(rst6), .din(din6), .dout(dout6), .chg(chg6)
`ifdef LTZ_CDCDB_EDGE_EN
        , .rise(rise6), .fall(fall6)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: dout flips once the last SC samples taken since its previous
    // flip all disagree with it.
    logic [W-1:0] din_hist[$];
    logic [W-1:0] samp_hist[$];
    int           since[W];
    logic [W-1:0] m_dout, m_chg;
    bit           model_on = 0;

    task automatic model_reset();
        din_hist  = {};
        samp_hist = {};
        for (int k = 0; k < SS; k++) din_hist.push_back('0);
        for (int i = 0; i < W; i++) since[i] = 0;
        m_dout = '0;
        m_chg  = '0;
    endtask

    task automatic model_step();
        logic [W-1:0] s;
        int n;
        bit all_diff;
        s = din_hist[din_hist.size() - SS];
        din_hist.push_back(din);
        samp_hist.push_back(s);
        m_chg = '0;
        n = samp_hist.size();
        for (int i = 0; i < W; i++) begin
            if (n - since[i] >= SC) begin
                all_diff = 1'b1;
                for (int k = n - SC; k < n; k++)
                    if (samp_hist[k][i] == m_dout[i]) all_diff = 1'b0;
                if (all_diff) begin
                    m_dout[i] = ~m_dout[i];
                    m_chg[i]  = 1'b1;
                    since[i]  = n;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (model_on) begin
            if (rst) model_reset();
            else model_step();
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic         rst;
        logic [W-1:0] din;
        logic [W-1:0] exp_dout;
        logic [W-1:0] exp_chg;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic [W-1:0] d, input logic [W-1:0] ed,
                       input logic [W-1:0] ec);
        vec_t v;
        v.rst = r; v.din = d; v.exp_dout = ed; v.exp_chg = ec;
        vq.push_back(v);
    endtask

    initial begin
        rst  = 1'b1;
        din  = '0;
        rst6 = 1'b1;
        din6 = 4'hA;

        // reset, hold zero, then din[0] step reaching dout on edge 6
        add(1, 4'h0, 4'h0, 4'h0); add(0, 4'h0, 4'h0, 4'h0); add(0, 4'h0, 4'h0, 4'h0);
        repeat (5) add(0, 4'h1, 4'h0, 4'h0);
        add(0, 4'h1, 4'h1, 4'h1); add(0, 4'h1, 4'h1, 4'h0);
        // din[1] 3 cycles high: rejected
        repeat (3) add(0, 4'h3, 4'h1, 4'h0);
        repeat (3) add(0, 4'h1, 4'h1, 4'h0);
        // din[1] 4 cycles high: accepted, then falls back after 4 lows
        repeat (4) add(0, 4'h3, 4'h1, 4'h0);
        add(0, 4'h1, 4'h1, 4'h0); add(0, 4'h1, 4'h3, 4'h2);
        repeat (3) add(0, 4'h1, 4'h3, 4'h0);
        add(0, 4'h1, 4'h1, 4'h2); add(0, 4'h1, 4'h1, 4'h0);
        // all channels at once
        add(1, 4'h0, 4'h0, 4'h0);
        repeat (5) add(0, 4'hF, 4'h0, 4'h0);
        add(0, 4'hF, 4'hF, 4'hF); add(0, 4'hF, 4'hF, 4'h0);
        // reset mid-count on din[2], count restarts after release
        add(1, 4'h0, 4'h0, 4'h0);
        repeat (3) add(0, 4'h4, 4'h0, 4'h0);
        add(1, 4'h4, 4'h0, 4'h0);
        repeat (5) add(0, 4'h4, 4'h0, 4'h0);
        add(0, 4'h4, 4'h4, 4'h4); add(0, 4'h4, 4'h4, 4'h0);

        @(negedge clk);
        foreach (vq[k]) begin
            rst = vq[k].rst;
            din = vq[k].din;
            tick();
            check($sformatf("tbl%0d_dout", k), dout, vq[k].exp_dout);
            check($sformatf("tbl%0d_chg", k), chg, vq[k].exp_chg);
`ifdef LTZ_CDCDB_EDGE_EN
            check($sformatf("tbl%0d_rise", k), rise, vq[k].exp_chg & vq[k].exp_dout);
            check($sformatf("tbl%0d_fall", k), fall, vq[k].exp_chg & ~vq[k].exp_dout);
`endif
        end

        // random run: alternate quiet and noisy stretches, occasional reset
        model_on = 1;
        rst = 1'b1;
        din = '0;
        tick();
        check("rnd_rst_dout", dout, m_dout);
        for (int blk = 0; blk < 40; blk++) begin
            int noise;
            noise = $urandom_range(0, 3);
            for (int c = 0; c < 64; c++) begin
                rst = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 9) < noise * 3) din = din ^ W'($urandom_range(1, 15));
                tick();
                check("rnd_dout", dout, m_dout);
                check("rnd_chg", chg, m_chg);
`ifdef LTZ_CDCDB_EDGE_EN
                check("rnd_rise", rise, m_chg & m_dout);
                check("rnd_fall", fall, m_chg & ~m_dout);
`endif
            end
        end
        model_on = 0;
        rst = 1'b0;

        // STABLE_CNT=1, SYNC_STAGES=3, INITVAL=A
        rst6 = 1'b1; din6 = 4'hA;
        tick();
        check("s6_rst_dout", dout6, 4'hA);
        check("s6_rst_chg", chg6, 4'h0);
        rst6 = 1'b0;
        repeat (2) begin tick(); check("s6_hold", dout6, 4'hA); end
        din6 = 4'h5;
        repeat (3) begin tick(); check("s6_lat_dout", dout6, 4'hA); check("s6_lat_chg", chg6, 4'h0); end
        tick();
        check("s6_step_dout", dout6, 4'h5);
        check("s6_step_chg", chg6, 4'hF);
        tick();
        check("s6_after_chg", chg6, 4'h0);
        din6 = 4'h4;
        tick();
        din6 = 4'h5;
        tick();
        tick();
        check("s6_pre_pulse", dout6, 4'h5);
        tick();
        check("s6_pulse_dout", dout6, 4'h4);
        check("s6_pulse_chg", chg6, 4'h1);
        tick();
        check("s6_pulse_end_dout", dout6, 4'h5);
        check("s6_pulse_end_chg", chg6, 4'h1);
        tick();
        check("s6_quiet_chg", chg6, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
